a25_copro15_ctrl: RTL and testbench



---
 rtl/a25_copro_pkg.sv | 29 ++
 rtl/a25_fault_fifo.sv | 69 ++++++
 rtl/a25_copro15_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_a25_copro15_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/a25_copro_pkg.sv
// Shared constants and types for the Amber 25 CP15 control block.
package a25_copro_pkg;

  // Coprocessor register numbers
  localparam logic [3:0] CRN_ID     = 4'd0;
  localparam logic [3:0] CRN_FLUSH  = 4'd1;
  localparam logic [3:0] CRN_CCTRL  = 4'd2;
  localparam logic [3:0] CRN_CACHE  = 4'd3;
  localparam logic [3:0] CRN_UPDATE = 4'd4;
  localparam logic [3:0] CRN_DISRPT = 4'd5;
  localparam logic [3:0] CRN_FSTAT  = 4'd6;
  localparam logic [3:0] CRN_FADDR  = 4'd7;
  localparam logic [3:0] CRN_STATUS = 4'd8;

  // Coprocessor operation codes
  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  // Bit positions in the status register
  localparam int unsigned STAT_OVF_BIT  = 31;
  localparam int unsigned STAT_TMO_BIT  = 30;
  localparam int unsigned STAT_BUSY_BIT = 29;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } flush_state_e;

endpackage

// File: rtl/a25_fault_fifo.sv
// Fault FIFO; a pop frees the slot a simultaneous push needs when full.
module a25_fault_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/a25_copro15_ctrl.sv
// CP15 register block: cache control, region masks, fault FIFO, flush handshake.
module a25_copro15_ctrl
  import a25_copro_pkg::*;
#(
  parameter int unsigned AREA_W        = 32,
  parameter int unsigned FAULT_DEPTH   = 4,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  parameter logic [31:0] ID_VALUE      = 32'h4156_0301
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_core_stall,
  input  logic [3:0]        i_copro_crn,
  input  logic [1:0]        i_copro_operation,
  input  logic [31:0]       i_copro_write_data,
  input  logic              i_fault,
  input  logic [7:0]        i_fault_status,
  input  logic [31:0]       i_fault_address,
  input  logic              i_cache_flush_done,
  output logic [31:0]       o_copro_read_data,
  output logic              o_cache_enable,
  output logic              o_cache_flush,
  output logic              o_flush_busy,
  output logic [AREA_W-1:0] o_cacheable_area,
  output logic [AREA_W-1:0] o_updateable_area,
  output logic [AREA_W-1:0] o_disruptive_area,
  output logic              o_fault_pending
);

  localparam int unsigned CntW = $clog2(FAULT_DEPTH) + 1;
  localparam int unsigned TmrW = $clog2(FLUSH_TIMEOUT);

  logic              mcr, mrc, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [39:0]       fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic [2:0]        cache_control_q, cache_control_d;
  logic [AREA_W-1:0] cacheable_q, cacheable_d, updateable_q, updateable_d;
  logic [AREA_W-1:0] disruptive_q, disruptive_d;
  logic              overflow_q, overflow_d, timeout_q, timeout_d, timeout_set;
  logic [31:0]       read_data_q, read_data_d, read_mux, status;
  flush_state_e      state_q, state_d;
  logic [TmrW-1:0]   timer_q, timer_d;

  assign mcr       = !i_core_stall && (i_copro_operation == OP_MCR);
  assign mrc       = !i_core_stall && (i_copro_operation == OP_MRC);
  assign fifo_push = i_fault && !i_core_stall;
  assign fifo_pop  = mcr && (i_copro_crn == CRN_STATUS);

  a25_fault_fifo #(
    .Depth (FAULT_DEPTH),
    .Width (40)
  ) u_fault_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (fifo_push),
    .wdata_i ({i_fault_status, i_fault_address}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Status word and read mux; reads see the pre-pop FIFO head
  always_comb begin
    status                = '0;
    status[STAT_OVF_BIT]  = overflow_q;
    status[STAT_TMO_BIT]  = timeout_q;
    status[STAT_BUSY_BIT] = (state_q != StIdle);
    status[CntW-1:0]      = fifo_count;
    read_mux              = '0;
    case (i_copro_crn)
      CRN_ID:     read_mux = ID_VALUE;
      CRN_CCTRL:  read_mux = {29'd0, cache_control_q};
      CRN_CACHE:  read_mux = 32'(cacheable_q);
      CRN_UPDATE: read_mux = 32'(updateable_q);
      CRN_DISRPT: read_mux = 32'(disruptive_q);
      CRN_FSTAT:  read_mux = {24'd0, fifo_head[39:32]};
      CRN_FADDR:  read_mux = fifo_head[31:0];
      CRN_STATUS: read_mux = status;
      default:    read_mux = '0;
    endcase
  end

  // Register-file next state; flag sets win over same-cycle clears
  always_comb begin
    cache_control_d = cache_control_q;
    cacheable_d     = cacheable_q;
    updateable_d    = updateable_q;
    disruptive_d    = disruptive_q;
    overflow_d      = overflow_q;
    timeout_d       = timeout_q;
    read_data_d     = mrc ? read_mux : read_data_q;
    if (mcr) begin
      case (i_copro_crn)
        CRN_CCTRL:  cache_control_d = i_copro_write_data[2:0];
        CRN_CACHE:  cacheable_d     = i_copro_write_data[AREA_W-1:0];
        CRN_UPDATE: updateable_d    = i_copro_write_data[AREA_W-1:0];
        CRN_DISRPT: disruptive_d    = i_copro_write_data[AREA_W-1:0];
        CRN_STATUS: begin
          if (i_copro_write_data[STAT_OVF_BIT]) overflow_d = 1'b0;
          if (i_copro_write_data[STAT_TMO_BIT]) timeout_d  = 1'b0;
        end
        default: ;
      endcase
    end
    // A pop in the same cycle makes room, so only an unpaired push overflows
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    if (timeout_set) timeout_d = 1'b1;
  end

  // Register-file state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cache_control_q <= '0;
      cacheable_q     <= '0;
      updateable_q    <= '0;
      disruptive_q    <= '0;
      overflow_q      <= 1'b0;
      timeout_q       <= 1'b0;
      read_data_q     <= '0;
    end else begin
      cache_control_q <= cache_control_d;
      cacheable_q     <= cacheable_d;
      updateable_q    <= updateable_d;
      disruptive_q    <= disruptive_d;
      overflow_q      <= overflow_d;
      timeout_q       <= timeout_d;
      read_data_q     <= read_data_d;
    end
  end

  // Flush FSM state and timeout counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Flush FSM next state; runs regardless of stall
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mcr && (i_copro_crn == CRN_FLUSH) && cache_control_q[0]) begin
          state_d = StFlush;
          timer_d = '0;
        end
      end
      StFlush: begin
        if (i_cache_flush_done) begin
          state_d = StIdle;
        end else if (timer_q == TmrW'(FLUSH_TIMEOUT - 1)) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_cache_flush     = (state_q == StFlush);
    o_flush_busy      = (state_q != StIdle);
    o_copro_read_data = read_data_q;
    o_cache_enable    = cache_control_q[0];
    o_cacheable_area  = cacheable_q;
    o_updateable_area = updateable_q;
    o_disruptive_area = disruptive_q;
    o_fault_pending   = !fifo_empty;
  end

endmodule

// File: tb/tb_a25_copro15_ctrl.sv
// Directed bench for a25_copro15_ctrl with small parameters.
module tb_a25_copro15_ctrl;

  localparam int unsigned AW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_core_stall = 1'b0;
  logic [3:0]    i_copro_crn = '0;
  logic [1:0]    i_copro_operation = '0;
  logic [31:0]   i_copro_write_data = '0;
  logic          i_fault = 1'b0;
  logic [7:0]    i_fault_status = '0;
  logic [31:0]   i_fault_address = '0;
  logic          i_cache_flush_done = 1'b0;
  logic [31:0]   o_copro_read_data;
  logic          o_cache_enable, o_cache_flush, o_flush_busy, o_fault_pending;
  logic [AW-1:0] o_cacheable_area, o_updateable_area, o_disruptive_area;

  int total = 0;
  int bad = 0;

  a25_copro15_ctrl #(
    .AREA_W        (AW),
    .FAULT_DEPTH   (4),
    .FLUSH_TIMEOUT (8),
    .ID_VALUE      (32'h4156_0301)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_core_stall       (i_core_stall),
    .i_copro_crn        (i_copro_crn),
    .i_copro_operation  (i_copro_operation),
    .i_copro_write_data (i_copro_write_data),
    .i_fault            (i_fault),
    .i_fault_status     (i_fault_status),
    .i_fault_address    (i_fault_address),
    .i_cache_flush_done (i_cache_flush_done),
    .o_copro_read_data  (o_copro_read_data),
    .o_cache_enable     (o_cache_enable),
    .o_cache_flush      (o_cache_flush),
    .o_flush_busy       (o_flush_busy),
    .o_cacheable_area   (o_cacheable_area),
    .o_updateable_area  (o_updateable_area),
    .o_disruptive_area  (o_disruptive_area),
    .o_fault_pending    (o_fault_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples live #1 after it
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mcr(input logic [3:0] crn, input logic [31:0] data);
    i_copro_operation  = 2'd2;
    i_copro_crn        = crn;
    i_copro_write_data = data;
    step();
    i_copro_operation  = 2'd0;
  endtask

  task automatic mrc(input logic [3:0] crn, output logic [31:0] data);
    i_copro_operation = 2'd1;
    i_copro_crn       = crn;
    step();
    i_copro_operation = 2'd0;
    data              = o_copro_read_data;
  endtask

  task automatic fault(input logic [31:0] addr, input logic [7:0] st);
    i_fault         = 1'b1;
    i_fault_address = addr;
    i_fault_status  = st;
    step();
    i_fault         = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    // Reset
    step();
    step();
    check("rst_rdata", o_copro_read_data, 32'h0);
    check("rst_outs", {28'd0, o_cache_enable, o_cache_flush, o_flush_busy, o_fault_pending},
          32'h0);
    check("rst_areas", {8'd0, o_cacheable_area, o_updateable_area, o_disruptive_area}, 32'h0);
    i_rst_n = 1'b1;
    step();

    mrc(4'd0, rd);
    check("id", rd, 32'h4156_0301);

    // Region masks
    mcr(4'd3, 32'hFFFF_FFA5);
    check("cacheable_out", 32'(o_cacheable_area), 32'hA5);
    mrc(4'd3, rd);
    check("cacheable_rd", rd, 32'h0000_00A5);
    mcr(4'd4, 32'h1234_563C);
    mcr(4'd5, 32'h0000_000F);
    check("upd_dis_out", {16'd0, o_updateable_area, o_disruptive_area}, 32'h3C0F);
    mrc(4'd9, rd);
    check("unmapped_rd", rd, 32'h0);

    // Stalled write and read are ignored
    i_core_stall = 1'b1;
    mcr(4'd3, 32'h0000_0011);
    mrc(4'd0, rd);
    i_core_stall = 1'b0;
    check("stall_write", 32'(o_cacheable_area), 32'hA5);
    check("stall_read", rd, 32'h0);

    // Cache control
    mcr(4'd2, 32'hFFFF_FFFF);
    check("cache_en", 32'(o_cache_enable), 32'h1);
    mrc(4'd2, rd);
    check("cctrl_rd", rd, 32'h7);

    // Fault FIFO: five faults into four slots
    fault(32'h100, 8'h01);
    check("pending", 32'(o_fault_pending), 32'h1);
    fault(32'h200, 8'h02);
    fault(32'h300, 8'h03);
    fault(32'h400, 8'h04);
    fault(32'h500, 8'h05);
    mrc(4'd8, rd);
    check("ovf_status", rd, 32'h8000_0004);
    mrc(4'd7, rd);
    check("head_addr", rd, 32'h100);
    mrc(4'd6, rd);
    check("head_stat", rd, 32'h1);
    mcr(4'd8, 32'h0);
    mrc(4'd7, rd);
    check("pop_addr", rd, 32'h200);
    fault(32'h550, 8'h55);
    mrc(4'd8, rd);
    check("refull", rd, 32'h8000_0004);

    // Pop and push together while full
    i_fault         = 1'b1;
    i_fault_address = 32'h600;
    i_fault_status  = 8'h06;
    mcr(4'd8, 32'h0);
    i_fault         = 1'b0;
    mrc(4'd8, rd);
    check("popush_full", rd, 32'h8000_0004);
    mcr(4'd8, 32'h0);
    mcr(4'd8, 32'h0);
    mcr(4'd8, 32'h0);
    mrc(4'd7, rd);
    check("tail_addr", rd, 32'h600);
    mrc(4'd6, rd);
    check("tail_stat", rd, 32'h6);
    mcr(4'd8, 32'h8000_0000);
    mrc(4'd8, rd);
    check("clear_ovf", rd, 32'h0);
    check("not_pending", 32'(o_fault_pending), 32'h0);
    mrc(4'd7, rd);
    check("empty_addr", rd, 32'h0);

    // Pop and push together while empty
    i_fault         = 1'b1;
    i_fault_address = 32'h700;
    i_fault_status  = 8'h07;
    mcr(4'd8, 32'h0);
    i_fault         = 1'b0;
    mrc(4'd8, rd);
    check("popush_empty", rd, 32'h1);
    mrc(4'd7, rd);
    check("popush_addr", rd, 32'h700);
    mcr(4'd8, 32'h0);

    // Flush with done in the fourth request cycle; second command is merged
    mcr(4'd1, 32'h0);
    check("flush_c1", {30'd0, o_cache_flush, o_flush_busy}, 32'h3);
    mcr(4'd1, 32'h0);
    check("flush_c2", 32'(o_cache_flush), 32'h1);
    mrc(4'd8, rd);
    check("busy_status", rd, 32'h2000_0000);
    check("flush_c3", 32'(o_cache_flush), 32'h1);
    step();
    check("flush_c4", 32'(o_cache_flush), 32'h1);
    i_cache_flush_done = 1'b1;
    step();
    i_cache_flush_done = 1'b0;
    check("flush_end", {30'd0, o_cache_flush, o_flush_busy}, 32'h0);
    step();
    step();
    check("no_extra", 32'(o_cache_flush), 32'h0);

    // Flush with cache disabled does nothing
    mcr(4'd2, 32'h0);
    mcr(4'd1, 32'h0);
    check("flush_disabled", 32'(o_cache_flush), 32'h0);

    // Timeout
    mcr(4'd2, 32'h1);
    mcr(4'd1, 32'h0);
    n = 0;
    while (o_cache_flush && n < 20) begin
      n++;
      step();
    end
    check("timeout_len", 32'(n), 32'd8);
    mrc(4'd8, rd);
    check("timeout_flag", rd, 32'h4000_0000);
    mcr(4'd8, 32'h4000_0000);
    mrc(4'd8, rd);
    check("timeout_clear", rd, 32'h0);

    // Asynchronous reset mid-flush
    mcr(4'd1, 32'h0);
    check("flush_pre_rst", 32'(o_cache_flush), 32'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_async", {30'd0, o_cache_flush, o_cache_enable}, 32'h0);
    step();
    i_rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
